// File: rtl/aes_v1_serial_pkg.sv
// Shared byte types and GF(2^8) arithmetic for the serial AES column unit.
// Used by the S-box and MixColumns datapaths.
package aes_v1_serial_pkg;

  typedef logic [7:0] byte_t;

  function automatic byte_t gf_xtime(byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gf_mul(byte_t a, byte_t b);
    byte_t acc;
    byte_t p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = gf_xtime(p);
    end
    return acc;
  endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
  function automatic byte_t gf_inv(byte_t a);
    byte_t r;
    byte_t t;
    r = 8'h01;
    t = a;
    for (int i = 1; i < 8; i++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    return r;
  endfunction

  function automatic byte_t aff_fwd(byte_t a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  function automatic byte_t aff_inv(byte_t s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

endpackage

// File: rtl/aes_v1_serial_if.sv
// Request/response bundle between the core execute stage and aes_v1_serial.
interface aes_v1_serial_if;
  logic        valid;
  logic        dec;
  logic        mix;
  logic [31:0] rs1;
  logic        ready;
  logic [31:0] rd;

  modport master (output valid, dec, mix, rs1, input ready, rd);
  modport slave  (input valid, dec, mix, rs1, output ready, rd);
endinterface

// File: rtl/aes_mixcolumn.sv
// (Inv)MixColumns on one 32-bit column {b3,b2,b1,b0}, b0 being row 0.
module aes_mixcolumn
  import aes_v1_serial_pkg::*;
#(
  parameter int DECRYPT_EN = 1
) (
  input  logic        dec,
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);
  logic inv;

  assign inv = dec & (DECRYPT_EN != 0);

  always_comb begin
    col_out = '0;
    for (int i = 0; i < 4; i++) begin
      if (inv)
        col_out[8*i +: 8] = gf_mul(col_in[8*i +: 8], 8'h0e)
                          ^ gf_mul(col_in[8*((i+1)%4) +: 8], 8'h0b)
                          ^ gf_mul(col_in[8*((i+2)%4) +: 8], 8'h0d)
                          ^ gf_mul(col_in[8*((i+3)%4) +: 8], 8'h09);
      else
        col_out[8*i +: 8] = gf_xtime(col_in[8*i +: 8])
                          ^ gf_mul(col_in[8*((i+1)%4) +: 8], 8'h03)
                          ^ col_in[8*((i+2)%4) +: 8]
                          ^ col_in[8*((i+3)%4) +: 8];
    end
  end
endmodule

// File: rtl/aes_sbox.sv
// Single AES S-box / inverse S-box; the GF inversion is shared by both directions.
module aes_sbox
  import aes_v1_serial_pkg::*;
#(
  parameter int DECRYPT_EN = 1
) (
  input  logic  dec,
  input  byte_t din,
  output byte_t dout
);
  logic  inv;
  byte_t pre;
  byte_t mid;

  assign inv  = dec & (DECRYPT_EN != 0);
  assign pre  = inv ? aff_inv(din) : din;
  assign mid  = gf_inv(pre);
  assign dout = inv ? mid : aff_fwd(mid);
endmodule

// File: rtl/aes_v1_serial.sv
// Multi-cycle AES column unit: SubBytes over NSBOX S-boxes in 4/NSBOX steps,
// MixColumns in a single step, behind an IDLE/BUSY/DONE handshake.
module aes_v1_serial
  import aes_v1_serial_pkg::*;
#(
  parameter int NSBOX      = 1,
  parameter int DECRYPT_EN = 1
) (
  input logic            g_clk,
  input logic            g_reset,
  aes_v1_serial_if.slave bus
);
  localparam int STEPS = (NSBOX > 0) ? 4 / NSBOX : 1;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  if (NSBOX != 1 && NSBOX != 2 && NSBOX != 4) begin : g_bad_nsbox
    $error("aes_v1_serial: NSBOX must be 1, 2 or 4");
  end

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      opnd_p0;
  logic             dec_p0;
  logic             mix_p0;
  logic             ready_q;
  logic [31:0]      rd_q;
  logic [31:0]      mix_out;
  logic             last_step;
  byte_t            sbox_in  [NSBOX];
  byte_t            sbox_out [NSBOX];

  assign last_step = (cnt_q == CNT_W'(STEPS - 1));

  // Operand bytes owned by the current step are steered onto the S-box lanes.
  always_comb begin
    for (int i = 0; i < NSBOX; i++) sbox_in[i] = '0;
    for (int b = 0; b < 4; b++)
      if (CNT_W'(b / NSBOX) == cnt_q) sbox_in[b % NSBOX] = opnd_p0[8*b +: 8];
  end

  for (genvar g = 0; g < NSBOX; g++) begin : g_sbox
    aes_sbox #(.DECRYPT_EN(DECRYPT_EN)) u_sbox (
      .dec  (dec_p0),
      .din  (sbox_in[g]),
      .dout (sbox_out[g])
    );
  end

  aes_mixcolumn #(.DECRYPT_EN(DECRYPT_EN)) u_mix (
    .dec     (dec_p0),
    .col_in  (opnd_p0),
    .col_out (mix_out)
  );

  // Stage p0: operand capture; result lanes written from the p0 operand.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      opnd_p0 <= '0;
      dec_p0  <= 1'b0;
      mix_p0  <= 1'b0;
      ready_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.valid) begin
            opnd_p0 <= bus.rs1;
            dec_p0  <= bus.dec & (DECRYPT_EN != 0);
            mix_p0  <= bus.mix;
            cnt_q   <= '0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mix_p0) begin
            rd_q    <= mix_out;
            ready_q <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            for (int b = 0; b < 4; b++)
              if (CNT_W'(b / NSBOX) == cnt_q) rd_q[8*b +: 8] <= sbox_out[b % NSBOX];
            if (last_step) begin
              cnt_q   <= '0;
              ready_q <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.rd    = rd_q;
endmodule

// File: tb/tb_aes_v1_serial.sv
// Directed bench: four unit variants (NSBOX 1/2/4, and NSBOX 1 without decrypt)
// driven in lockstep from a vector table, plus reset and back-to-back sequences.
module tb_aes_v1_serial;
  logic g_clk = 1'b0;
  logic g_reset;

  always #5 g_clk = ~g_clk;

  aes_v1_serial_if b1 ();
  aes_v1_serial_if b2 ();
  aes_v1_serial_if b4 ();
  aes_v1_serial_if bn ();

  aes_v1_serial #(.NSBOX(1), .DECRYPT_EN(1)) u_n1 (.g_clk(g_clk), .g_reset(g_reset), .bus(b1));
  aes_v1_serial #(.NSBOX(2), .DECRYPT_EN(1)) u_n2 (.g_clk(g_clk), .g_reset(g_reset), .bus(b2));
  aes_v1_serial #(.NSBOX(4), .DECRYPT_EN(1)) u_n4 (.g_clk(g_clk), .g_reset(g_reset), .bus(b4));
  aes_v1_serial #(.NSBOX(1), .DECRYPT_EN(0)) u_nd (.g_clk(g_clk), .g_reset(g_reset), .bus(bn));

  logic        rdy [4];
  logic [31:0] rdv [4];
  assign rdy[0] = b1.ready;
  assign rdy[1] = b2.ready;
  assign rdy[2] = b4.ready;
  assign rdy[3] = bn.ready;
  assign rdv[0] = b1.rd;
  assign rdv[1] = b2.rd;
  assign rdv[2] = b4.rd;
  assign rdv[3] = bn.rd;

  typedef struct {
    logic        dec;
    logic        mix;
    logic [31:0] rs1;
    logic [31:0] exp_rd;
    logic        chk_nd;
    logic [31:0] exp_nd;
  } vec_t;

  vec_t        vecs [10];
  int          sub_lat [4];
  int          n_chk;
  int          n_fail;
  int          obs_cnt [4];
  int          obs_first [4];
  logic [31:0] obs_rd [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic d, input logic m, input logic [31:0] r);
    b1.valid = v; b1.dec = d; b1.mix = m; b1.rs1 = r;
    b2.valid = v; b2.dec = d; b2.mix = m; b2.rs1 = r;
    b4.valid = v; b4.dec = d; b4.mix = m; b4.rs1 = r;
    bn.valid = v; bn.dec = d; bn.mix = m; bn.rs1 = r;
  endtask

  // Samples cycles 1..ncyc at the falling edge; in cycle 1 optionally drops
  // valid and scrambles the request inputs after the accept.
  task automatic observe(input int ncyc, input logic hold, input logic scramble);
    for (int d = 0; d < 4; d++) begin
      obs_cnt[d] = 0; obs_first[d] = -1; obs_rd[d] = '0;
    end
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge g_clk);
      for (int d = 0; d < 4; d++)
        if (rdy[d]) begin
          obs_cnt[d]++;
          if (obs_first[d] < 0) begin obs_first[d] = c; obs_rd[d] = rdv[d]; end
        end
      if (c == 1) begin
        if (scramble) drive(hold, ~b1.dec, ~b1.mix, 32'hFFFF_FFFF);
        else if (!hold) drive(1'b0, b1.dec, b1.mix, b1.rs1);
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    sub_lat = '{5, 3, 2, 5};
    vecs[0] = '{1'b0, 1'b0, 32'h5300_6300, 32'hED63_FB63, 1'b1, 32'hED63_FB63};
    vecs[1] = '{1'b1, 1'b0, 32'hED63_FB63, 32'h5300_6300, 1'b1, 32'h55FB_0FFB};
    vecs[2] = '{1'b0, 1'b1, 32'h4553_13DB, 32'hBCA1_4D8E, 1'b1, 32'hBCA1_4D8E};
    vecs[3] = '{1'b1, 1'b1, 32'hBCA1_4D8E, 32'h4553_13DB, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 32'h0123_4567, 32'h7C26_6E85, 1'b1, 32'h7C26_6E85};
    vecs[5] = '{1'b1, 1'b0, 32'h7C26_6E85, 32'h0123_4567, 1'b1, 32'h10F7_9F97};
    vecs[6] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1616_1616, 1'b1, 32'h1616_1616};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0000, 32'h5252_5252, 1'b1, 32'h6363_6363};
    vecs[8] = '{1'b0, 1'b1, 32'h5C22_0AF2, 32'h9D58_DC9F, 1'b1, 32'h9D58_DC9F};
    vecs[9] = '{1'b1, 1'b1, 32'h9D58_DC9F, 32'h5C22_0AF2, 1'b0, 32'h0};

    g_reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) @(negedge g_clk);
    g_reset = 1'b0;
    for (int d = 0; d < 4; d++) begin
      check($sformatf("reset_ready_d%0d", d), 32'(rdy[d]), 32'h0);
      check($sformatf("reset_rd_d%0d", d), rdv[d], 32'h0);
    end

    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].dec, vecs[i].mix, vecs[i].rs1);
      observe(8, 1'b0, 1'b1);
      for (int d = 0; d < 4; d++) begin
        check($sformatf("v%0d_d%0d_npulse", i, d), 32'(obs_cnt[d]), 32'd1);
        check($sformatf("v%0d_d%0d_lat", i, d), 32'(obs_first[d]),
              vecs[i].mix ? 32'd2 : 32'(sub_lat[d]));
        if (d < 3) check($sformatf("v%0d_d%0d_rd", i, d), obs_rd[d], vecs[i].exp_rd);
        else if (vecs[i].chk_nd) check($sformatf("v%0d_nodec_rd", i), obs_rd[d], vecs[i].exp_nd);
      end
    end

    // Reset asserted in cycle 2 of a NSBOX=1 SubBytes.
    drive(1'b1, 1'b0, 1'b0, 32'h5300_6300);
    @(negedge g_clk);
    drive(1'b0, 1'b0, 1'b0, 32'h5300_6300);
    @(negedge g_clk);
    g_reset = 1'b1;
    @(negedge g_clk);
    g_reset = 1'b0;
    check("midrst_ready", 32'(rdy[0]), 32'h0);
    check("midrst_rd", rdv[0], 32'h0);
    observe(8, 1'b0, 1'b0);
    for (int d = 0; d < 4; d++)
      check($sformatf("midrst_nopulse_d%0d", d), 32'(obs_cnt[d]), 32'd0);
    check("midrst_rd_after", rdv[0], 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h5300_6300);
    observe(8, 1'b0, 1'b0);
    check("fresh_npulse", 32'(obs_cnt[0]), 32'd1);
    check("fresh_lat", 32'(obs_first[0]), 32'd5);
    check("fresh_rd", obs_rd[0], 32'hED63_FB63);

    // Reset in the same cycle as valid: the request must be dropped.
    drive(1'b1, 1'b0, 1'b1, 32'h0123_4567);
    g_reset = 1'b1;
    @(negedge g_clk);
    g_reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    observe(8, 1'b0, 1'b0);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("rstvalid_nopulse_d%0d", d), 32'(obs_cnt[d]), 32'd0);
      check($sformatf("rstvalid_rd_d%0d", d), rdv[d], 32'h0);
    end

    // valid held high: one pulse per accept, re-accept right after DONE.
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0000);
    observe(12, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check("hold_npulse_n1", 32'(obs_cnt[0]), 32'd2);
    check("hold_npulse_n2", 32'(obs_cnt[1]), 32'd3);
    check("hold_npulse_n4", 32'(obs_cnt[2]), 32'd4);
    check("hold_npulse_nd", 32'(obs_cnt[3]), 32'd2);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("hold_lat_d%0d", d), 32'(obs_first[d]), 32'(sub_lat[d]));
      check($sformatf("hold_rd_d%0d", d), obs_rd[d], 32'h6363_6363);
    end
    observe(8, 1'b0, 1'b0);
    for (int d = 0; d < 4; d++)
      check($sformatf("hold_drain_d%0d", d), 32'(obs_cnt[d]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
